// File: rtl/if_id_skid_reg.sv
// Two-entry IF/ID skid buffer: a registered head plus a skid slot, so the
// ready seen by fetch never depends on decode's ready in the same cycle.
module if_id_skid_reg #(
    parameter int                  NB_DATA  = 32,
    parameter int                  NB_PC    = 7,
    parameter logic [NB_DATA-1:0]  NOP_WORD = 32'h0000_0000,
    parameter int                  NB_CNT   = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               en_pipeline_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [NB_PC-1:0]   pc_i,
    input  logic [NB_DATA-1:0] instruction_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [NB_PC-1:0]   pc_o,
    output logic [NB_DATA-1:0] instruction_o,
    output logic [1:0]         occupancy_o,
    output logic [NB_CNT-1:0]  flush_drops_o
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [NB_PC-1:0]   pc;
        logic [NB_DATA-1:0] instr;
    } entry_t;

    localparam entry_t BUBBLE = '{pc: '0, instr: NOP_WORD};

    state_t              state;
    entry_t              head;
    entry_t              skid;
    entry_t              in_entry;
    logic                push;
    logic                pop;
    logic [NB_CNT:0]     drops_sum;
    logic [NB_CNT-1:0]   flush_drops;

    assign in_entry    = '{pc: pc_i, instr: instruction_i};
    assign in_ready_o  = en_pipeline_i & (state != TWO);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i & en_pipeline_i;

    assign pc_o          = head.pc;
    assign instruction_o = head.instr;
    assign flush_drops_o = flush_drops;

    // One extra bit catches the wrap so the counter can pin at all-ones.
    assign drops_sum = {1'b0, flush_drops} + (NB_CNT+1)'(occupancy_o);

    // Pipeline registers in this core update on the falling edge.
    always_ff @(negedge clock_i) begin
        if (reset_i) begin
            state       <= EMPTY;
            head        <= BUBBLE;
            skid        <= BUBBLE;
            out_valid_o <= 1'b0;
            occupancy_o <= 2'd0;
            flush_drops <= '0;
        end else if (flush_i) begin
            state       <= EMPTY;
            head        <= BUBBLE;
            skid        <= BUBBLE;
            out_valid_o <= 1'b0;
            occupancy_o <= 2'd0;
            flush_drops <= drops_sum[NB_CNT] ? {NB_CNT{1'b1}} : drops_sum[NB_CNT-1:0];
        end else if (en_pipeline_i) begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state       <= ONE;
                        head        <= in_entry;
                        out_valid_o <= 1'b1;
                        occupancy_o <= 2'd1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= in_entry;
                    end else if (push) begin
                        state       <= TWO;
                        skid        <= in_entry;
                        occupancy_o <= 2'd2;
                    end else if (pop) begin
                        state       <= EMPTY;
                        head        <= BUBBLE;
                        out_valid_o <= 1'b0;
                        occupancy_o <= 2'd0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state       <= ONE;
                        head        <= skid;
                        occupancy_o <= 2'd1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    head        <= BUBBLE;
                    out_valid_o <= 1'b0;
                    occupancy_o <= 2'd0;
                end
            endcase
        end
    end

endmodule
